// File: rtl/mbox_responder_pkg.sv
// mbox_responder_pkg: shared word/address types, FSM states and latency helper
// for the EBOX<->MBOX word-request responder.
package mbox_responder_pkg;

    typedef logic [0:35] word_t;
    typedef logic [14:35] padr_t;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT
    } state_e;

    localparam int CNT_W = 4;

    // Counter preload so that ack lands exactly `lat` edges after accept.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mbox_core_ram.sv
// mbox_core_ram: 2^ADDR_WIDTH x 36 backing store with one synchronous write
// port and a registered read port that holds its value until the next read.
module mbox_core_ram
    import mbox_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wadr_i,
    input  logic [0:35]           wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] radr_i,
    output logic [0:35]           rdata_o
);

    word_t mem [2**ADDR_WIDTH];
    word_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[wadr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        rdata_q <= rst ? '0 : re_i ? mem[radr_i] : rdata_q;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mbox_responder.sv
// mbox_responder: stand-in MBOX that services one-word EBOX read/write requests
// from a local core array after a fixed latency, with a backdoor preload port.
module mbox_responder
    import mbox_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        reqWrite,
    input  logic [14:35] reqAdr,
    input  logic [0:35] writeData,
    input  logic        loadEn,
    input  logic [14:35] loadAdr,
    input  logic [0:35] loadData,
    output logic        busy,
    output logic        ack,
    output logic [0:35] cacheDataRead,
    output logic        reqErr
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    word_t                 data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  done, accept, commit, preload;
    logic [ADDR_WIDTH-1:0] req_idx, load_idx;
    logic                  unused_adr;

    // Upper address bits beyond the backing store are ignored (wrap).
    assign req_idx    = reqAdr[36-ADDR_WIDTH +: ADDR_WIDTH];
    assign load_idx   = loadAdr[36-ADDR_WIDTH +: ADDR_WIDTH];
    assign unused_adr = ^{reqAdr[14 +: 22-ADDR_WIDTH], loadAdr[14 +: 22-ADDR_WIDTH]};

    always_comb begin
        done    = state_q != IDLE && cnt_q == '0;
        // busy is already low in the completing cycle, so a new request can
        // overlap the completion and latency-1 streams run every cycle.
        accept  = req && !busy_q;
        state_d = accept ? (reqWrite ? WRITE_WAIT : READ_WAIT) : done ? IDLE : state_q;
        cnt_d   = accept ? (reqWrite ? lat_load(WRITE_LATENCY) : lat_load(READ_LATENCY))
                : state_q != IDLE && !done ? cnt_q - CNT_W'(1) : '0;
        adr_d   = accept ? req_idx : adr_q;
        data_d  = accept ? writeData : data_q;
        busy_d  = state_d != IDLE && cnt_d != '0;
        ack_d   = done;
        err_d   = req && busy_q;
        commit  = done && state_q == WRITE_WAIT && !reset;
        preload = loadEn && !req && state_q == IDLE && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    mbox_core_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (reset),
        .we_i   (commit || preload),
        .wadr_i (commit ? adr_q : load_idx),
        .wdata_i(commit ? data_q : loadData),
        .re_i   (done && state_q == READ_WAIT),
        .radr_i (adr_q),
        .rdata_o(cacheDataRead)
    );

    assign busy   = busy_q;
    assign ack    = ack_q;
    assign reqErr = err_q;

endmodule
